uart_in_source: RTL and testbench
=================================

# uart_in_source

Simulation-side responder for the SoC UART input channel. It holds host-supplied characters in a FIFO and answers each DUT read strobe (`io_uart_in_valid`) with the next character. When no character is available it answers with the no-character code 0xFF, which is the value the top-level bench currently ties off. It sits in `tb_top` between the host-side DPI/plusarg character feeder and `SimTop`'s `io_uart_in_*` ports.

## Interface
- `DEPTH`, default 16: FIFO entries. Must be a power of two, 2..256.
- `GAP_CYCLES`, default 0: minimum cycles after a delivered character before the next is offered. 0 disables pacing.
- `LW`, derived as $clog2(DEPTH)+1: width of `level`.
- `clock` in 1: the only clock. All logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset. Assertion acts immediately; deassertion is synchronous to `clock`.
- `push_valid` in 1: host offers `push_ch`.
- `push_ch` in 8: character from the host.
- `push_ready` out 1: FIFO can accept. A push occurs when `push_valid && push_ready` at a clock edge.
- `flush` in 1: drop all queued characters and any pending gap.
- `io_uart_in_valid` in 1: DUT read strobe. Each cycle it is high counts as one read.
- `io_uart_in_ch` out 8: character returned for the read in the same cycle.
- `level` out LW: number of queued characters.
- `rd_count` out 32: number of characters delivered. Saturates.
- `empty_rd_count` out 32: number of reads answered with 0xFF. Saturates.

## Operation
FSM has two states: READY and GAP.
- READY, FIFO non-empty:
  - `io_uart_in_ch` = FIFO head.
  - A read pops the head and increments `rd_count`.
  - If GAP_CYCLES > 0, the read loads the gap counter with GAP_CYCLES and the FSM goes to GAP.
- READY, FIFO empty:
  - `io_uart_in_ch` = 0xFF.
  - A read increments `empty_rd_count`; nothing is popped.
- GAP:
  - `io_uart_in_ch` = 0xFF regardless of FIFO level.
  - A read increments `empty_rd_count`.
  - The counter decrements each cycle. The FSM returns to READY in the cycle after the counter reaches 1.
  - Result: exactly GAP_CYCLES cycles of 0xFF follow a delivery.
- Push side:
  - `push_ready` = !full, computed from the registered level only.
  - When full, a push is refused even if a pop happens in the same cycle.
  - A push and a pop in the same cycle are both honoured; `level` stays unchanged.
- Flush:
  - Highest priority. In that cycle: FIFO emptied, FSM forced to READY, gap counter cleared.
  - A push or pop in the flush cycle is discarded and not counted.
  - A read in the flush cycle is answered from the pre-flush state and counted as that answer dictates: delivered → `rd_count`, 0xFF → `empty_rd_count`.
  - Flush does not clear the counters.
- Counters hold at 0xFFFF_FFFF.
- Pointers wrap modulo DEPTH. `level` distinguishes full (DEPTH) from empty (0).
- A character whose top bit is set (≥0x80) is queued and delivered like any other. Only the 0xFF answered on a no-character read is the "no character" code. The host must not push 0xFF; if it does, the byte is delivered and counted in `rd_count`.

## Timing
- `io_uart_in_ch` is combinational from registered state only: head entry, level, FSM state. There is no path from `push_ch`/`push_valid` to it.
- A character pushed at edge N is visible on `io_uart_in_ch` after edge N, and can be read from cycle N+1 onward.
- Back-to-back reads with GAP_CYCLES = 0 deliver one character per cycle.
- `level`, `push_ready` and the counters update at the edge ending the cycle in which the event occurs.
- Reset values:
  - `push_ready` = 1, `level` = 0, `rd_count` = 0, `empty_rd_count` = 0.
  - `io_uart_in_ch` = 0xFF, FSM = READY, gap counter = 0.
- Reset asserted mid-gap or with data queued: everything returns to reset values immediately, with no clock needed.

## Structure
- Package `uart_in_pkg`:
  - `UART_NO_CHAR` = 8'hFF.
  - FSM state enum (READY, GAP).
  - Counter width constant `UART_CNT_W` = 32.
- Sub-module `uart_in_fifo`: synchronous FIFO with registered pointers and level, combinational head output, and flush. Parameterised by DEPTH and width 8.
- Top module contains the FSM, gap counter and saturating counters.

## Test plan
- Reset, then 3 read strobes with nothing pushed: `io_uart_in_ch` = 0xFF each cycle, `empty_rd_count` = 3, `rd_count` = 0.
- GAP_CYCLES = 0. Push 'h','i','\n' (0x68, 0x69, 0x0A), then read 3 consecutive cycles: 0x68, 0x69, 0x0A in order, `level` back to 0, `rd_count` = 3.
- DEPTH = 16. Push 17 characters with `push_valid` held high: 16 accepted, `push_ready` = 0 while full. Then, full, assert a push and a read in the same cycle: the push is refused, `level` drops to 15, and `push_ready` = 1 on the next cycle.
- GAP_CYCLES = 4. Queue 0x41, 0x42 and read every cycle: 0x41, then 4 reads answered 0xFF, then 0x42. `empty_rd_count` = 4.
- With 5 queued, assert `flush` together with a push and a read: the read returns the old head and is counted in `rd_count`, the push is dropped, `level` = 0 after the edge, and the counters are not cleared.
- With 3 queued and GAP active, assert `reset` low between edges: outputs go to reset values immediately. After release, a read returns 0xFF.

Source files
------------

// File: rtl/uart_in_pkg.sv
// Shared constants and state encoding for the UART input-channel responder.
package uart_in_pkg;

  localparam logic [7:0] UART_NO_CHAR = 8'hFF;
  localparam int         UART_CNT_W   = 32;

  typedef enum logic [0:0] {
    ST_READY = 1'b0,
    ST_GAP   = 1'b1
  } uart_in_state_e;

endpackage

// File: rtl/uart_in_source_if.sv
// Host-side and DUT-side signals of the UART input responder, grouped as one bundle.
interface uart_in_source_if #(
  parameter int DEPTH = 16
);
  import uart_in_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;

  logic                  push_valid;
  logic [7:0]            push_ch;
  logic                  push_ready;
  logic                  flush;
  logic                  io_uart_in_valid;
  logic [7:0]            io_uart_in_ch;
  logic [LW-1:0]         level;
  logic [UART_CNT_W-1:0] rd_count;
  logic [UART_CNT_W-1:0] empty_rd_count;

  modport master (
    output push_valid, push_ch, flush, io_uart_in_valid,
    input  push_ready, io_uart_in_ch, level, rd_count, empty_rd_count
  );

  modport slave (
    input  push_valid, push_ch, flush, io_uart_in_valid,
    output push_ready, io_uart_in_ch, level, rd_count, empty_rd_count
  );

endinterface

// File: rtl/uart_in_fifo.sv
// Synchronous FIFO with registered pointers/level, combinational head and flush.
module uart_in_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; level alone decides whether the head is valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end

endmodule

// File: rtl/uart_in_source.sv
// Answers each UART read strobe with the next queued host character, or 0xFF when none
// is available or the post-delivery pacing gap is still running.
module uart_in_source
  import uart_in_pkg::*;
#(
  parameter  int DEPTH      = 16,
  parameter  int GAP_CYCLES = 0,
  localparam int LW         = $clog2(DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset,
  uart_in_source_if.slave bus
);

  localparam int         GW      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [0:0] S_READY = ST_READY;
  localparam logic [0:0] S_GAP   = ST_GAP;

  logic [0:0]            state;
  logic [GW-1:0]         gap_cnt;
  logic [UART_CNT_W-1:0] rd_cnt;
  logic [UART_CNT_W-1:0] empty_cnt;
  logic [7:0]            head;
  logic [LW-1:0]         level;
  logic                  full;
  logic                  empty;
  logic                  deliver;
  logic                  push;
  logic                  pop;

  function automatic logic [UART_CNT_W-1:0] sat_inc(input logic [UART_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // The answer depends only on registered state, never on this cycle's push.
  assign deliver = (state == S_READY) && !empty;
  assign pop     = bus.io_uart_in_valid && deliver && !bus.flush;
  assign push    = bus.push_valid && !full && !bus.flush;

  assign bus.io_uart_in_ch  = deliver ? head : UART_NO_CHAR;
  assign bus.push_ready     = !full;
  assign bus.level          = level;
  assign bus.rd_count       = rd_cnt;
  assign bus.empty_rd_count = empty_cnt;

  uart_in_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.flush),
    .din   (bus.push_ch),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_READY;
      gap_cnt   <= '0;
      rd_cnt    <= '0;
      empty_cnt <= '0;
    end else begin
      // A read in a flush cycle is still counted by what it was answered with.
      if (bus.io_uart_in_valid) begin
        if (deliver) rd_cnt    <= sat_inc(rd_cnt);
        else         empty_cnt <= sat_inc(empty_cnt);
      end
      if (bus.flush) begin
        state   <= S_READY;
        gap_cnt <= '0;
      end else if (state == S_GAP) begin
        if (gap_cnt == GW'(1)) begin
          state   <= S_READY;
          gap_cnt <= '0;
        end else begin
          gap_cnt <= gap_cnt - 1'b1;
        end
      end else if (pop && (GAP_CYCLES > 0)) begin
        state   <= S_GAP;
        gap_cnt <= GW'(GAP_CYCLES);
      end
    end
  end

endmodule

// File: tb/tb_uart_in_source.sv
// Bench driving two responders (no pacing, 4-cycle pacing) in lockstep against a queue model.
module tb_uart_in_source;

  localparam int DEPTH = 16;
  localparam int G0    = 0;
  localparam int G1    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  uart_in_source_if #(.DEPTH(DEPTH)) b0 ();
  uart_in_source_if #(.DEPTH(DEPTH)) b1 ();

  uart_in_source #(.DEPTH(DEPTH), .GAP_CYCLES(G0)) dut0 (.clock(clk), .reset(rst_n), .bus(b0));
  uart_in_source #(.DEPTH(DEPTH), .GAP_CYCLES(G1)) dut1 (.clock(clk), .reset(rst_n), .bus(b1));

  // Model: queued characters, remaining 0xFF cycles, and the two counters.
  logic [7:0]  mq [2][$];
  int          mgap [2];
  logic [31:0] mrd [2];
  logic [31:0] merd [2];
  logic [7:0]  exp_ch [2];
  logic [7:0]  got_ch [2];
  logic        got_rdy [2];

  function automatic int gap_of(int d);
    return (d == 0) ? G0 : G1;
  endfunction

  function automatic logic [31:0] sinc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [4:0] lvl_of(int d);
    return (d == 0) ? b0.level : b1.level;
  endfunction
  function automatic logic rdy_of(int d);
    return (d == 0) ? b0.push_ready : b1.push_ready;
  endfunction
  function automatic logic [7:0] ch_of(int d);
    return (d == 0) ? b0.io_uart_in_ch : b1.io_uart_in_ch;
  endfunction
  function automatic logic [31:0] rdc_of(int d);
    return (d == 0) ? b0.rd_count : b1.rd_count;
  endfunction
  function automatic logic [31:0] erdc_of(int d);
    return (d == 0) ? b0.empty_rd_count : b1.empty_rd_count;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      mgap[d] = 0;
      mrd[d]  = 32'd0;
      merd[d] = 32'd0;
    end
  endtask

  task automatic model_cycle(int d, logic pv, logic [7:0] ch, logic rd, logic fl);
    bit dlv;
    bit was_full;
    dlv      = (mgap[d] == 0) && (mq[d].size() > 0);
    was_full = (mq[d].size() == DEPTH);
    exp_ch[d] = dlv ? mq[d][0] : 8'hFF;
    if (rd) begin
      if (dlv) mrd[d] = sinc(mrd[d]);
      else     merd[d] = sinc(merd[d]);
    end
    if (fl) begin
      mq[d].delete();
      mgap[d] = 0;
    end else begin
      if (mgap[d] > 0) mgap[d]--;
      if (rd && dlv) begin
        void'(mq[d].pop_front());
        mgap[d] = gap_of(d);
      end
      if (pv && !was_full) mq[d].push_back(ch);
    end
  endtask

  task automatic set_inputs(logic pv, logic [7:0] ch, logic rd, logic fl);
    b0.push_valid = pv; b0.push_ch = ch; b0.io_uart_in_valid = rd; b0.flush = fl;
    b1.push_valid = pv; b1.push_ch = ch; b1.io_uart_in_valid = rd; b1.flush = fl;
  endtask

  // One clock cycle: drive, capture combinational answers, advance the model, pass the edge.
  task automatic step(logic pv, logic [7:0] ch, logic rd, logic fl);
    @(negedge clk);
    set_inputs(pv, ch, rd, fl);
    #1;
    for (int d = 0; d < 2; d++) begin
      got_ch[d]  = ch_of(d);
      got_rdy[d] = rdy_of(d);
      model_cycle(d, pv, ch, rd, fl);
    end
    @(posedge clk);
    #1;
    set_inputs(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ch_of(d) !== 8'hFF || lvl_of(d) !== 5'd0 || rdy_of(d) !== 1'b1 ||
          rdc_of(d) !== 32'd0 || erdc_of(d) !== 32'd0) begin
        errors++;
        $display("FAIL reset_values dut%0d: ch=%h level=%0d ready=%b rd=%0d erd=%0d, required ch=ff level=0 ready=1 rd=0 erd=0",
                 d, ch_of(d), lvl_of(d), rdy_of(d), rdc_of(d), erdc_of(d));
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (got_ch[d] !== 8'hFF) begin
          errors++;
          $display("FAIL empty_read dut%0d #%0d: got %h, required ff", d, i, got_ch[d]);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (erdc_of(d) !== 32'd3 || rdc_of(d) !== 32'd0) begin
        errors++;
        $display("FAIL empty_counts dut%0d: erd=%0d rd=%0d, required erd=3 rd=0", d, erdc_of(d), rdc_of(d));
      end
    end
  endtask

  task automatic test_order();
    logic [7:0] msg [3];
    logic [31:0] base;
    msg = '{8'h68, 8'h69, 8'h0A};
    base = mrd[0];
    for (int i = 0; i < 3; i++) step(1'b1, msg[i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (got_ch[0] !== msg[i]) begin
        errors++;
        $display("FAIL order dut0 #%0d: got %h, required %h", i, got_ch[0], msg[i]);
      end
      checks++;
      if (got_ch[1] !== exp_ch[1]) begin
        errors++;
        $display("FAIL order dut1 #%0d: got %h, required %h", i, got_ch[1], exp_ch[1]);
      end
    end
    checks++;
    if (b0.level !== 5'd0 || b0.rd_count !== base + 32'd3) begin
      errors++;
      $display("FAIL order_after dut0: level=%0d rd=%0d, required level=0 rd=%0d", b0.level, b0.rd_count, base + 32'd3);
    end
  endtask

  task automatic test_full();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (got_rdy[d] !== (i < 16)) begin
          errors++;
          $display("FAIL fill_ready dut%0d push %0d: ready=%b, required %b", d, i, got_rdy[d], (i < 16));
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (lvl_of(d) !== 5'd16 || rdy_of(d) !== 1'b0) begin
        errors++;
        $display("FAIL full_state dut%0d: level=%0d ready=%b, required level=16 ready=0", d, lvl_of(d), rdy_of(d));
      end
    end
    step(1'b1, 8'h7E, 1'b1, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got_ch[d] !== 8'h20) begin
        errors++;
        $display("FAIL full_pop_ch dut%0d: got %h, required 20", d, got_ch[d]);
      end
      checks++;
      if (lvl_of(d) !== 5'd15 || rdy_of(d) !== 1'b1 || lvl_of(d) !== 5'(mq[d].size())) begin
        errors++;
        $display("FAIL full_push_refused dut%0d: level=%0d ready=%b, required level=15 ready=1", d, lvl_of(d), rdy_of(d));
      end
    end
  endtask

  task automatic test_gap();
    logic [7:0]  seq [6];
    logic [31:0] base;
    seq = '{8'h41, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h42};
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    base = merd[1];
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (got_ch[1] !== seq[i]) begin
        errors++;
        $display("FAIL gap_seq dut1 #%0d: got %h, required %h", i, got_ch[1], seq[i]);
      end
      checks++;
      if (got_ch[0] !== exp_ch[0]) begin
        errors++;
        $display("FAIL gap_seq dut0 #%0d: got %h, required %h", i, got_ch[0], exp_ch[0]);
      end
    end
    checks++;
    if (b1.empty_rd_count !== base + 32'd4) begin
      errors++;
      $display("FAIL gap_empty_count dut1: got %0d, required %0d", b1.empty_rd_count, base + 32'd4);
    end
  endtask

  task automatic test_flush();
    logic [7:0]  first;
    logic [31:0] rd_before [2];
    logic [31:0] erd_before [2];
    step(1'b0, 8'h00, 1'b0, 1'b1);
    first = 8'($urandom_range(0, 254));
    step(1'b1, first, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom_range(0, 254)), 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      rd_before[d]  = mrd[d];
      erd_before[d] = merd[d];
    end
    step(1'b1, 8'h55, 1'b1, 1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got_ch[d] !== first) begin
        errors++;
        $display("FAIL flush_read dut%0d: got %h, required %h", d, got_ch[d], first);
      end
      checks++;
      if (lvl_of(d) !== 5'd0 || rdc_of(d) !== rd_before[d] + 32'd1 || erdc_of(d) !== erd_before[d]) begin
        errors++;
        $display("FAIL flush_after dut%0d: level=%0d rd=%0d erd=%0d, required level=0 rd=%0d erd=%0d",
                 d, lvl_of(d), rdc_of(d), erdc_of(d), rd_before[d] + 32'd1, erd_before[d]);
      end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got_ch[d] !== 8'hFF) begin
        errors++;
        $display("FAIL flush_push_dropped dut%0d: got %h, required ff", d, got_ch[d]);
      end
    end
  endtask

  task automatic test_reset_midgap();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (b1.level !== 5'd3 || b1.io_uart_in_ch !== 8'hFF) begin
      errors++;
      $display("FAIL midgap_setup dut1: level=%0d ch=%h, required level=3 ch=ff", b1.level, b1.io_uart_in_ch);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ch_of(d) !== 8'hFF || lvl_of(d) !== 5'd0 || rdy_of(d) !== 1'b1 ||
          rdc_of(d) !== 32'd0 || erdc_of(d) !== 32'd0) begin
        errors++;
        $display("FAIL async_reset dut%0d: ch=%h level=%0d ready=%b rd=%0d erd=%0d, required ff/0/1/0/0",
                 d, ch_of(d), lvl_of(d), rdy_of(d), rdc_of(d), erdc_of(d));
      end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got_ch[d] !== 8'hFF) begin
        errors++;
        $display("FAIL post_reset_read dut%0d: got %h, required ff", d, got_ch[d]);
      end
    end
  endtask

  task automatic test_random();
    logic pv, rd, fl;
    logic [7:0] ch;
    for (int n = 0; n < 400; n++) begin
      pv = ($urandom_range(0, 9) < 6);
      rd = ($urandom_range(0, 9) < 5);
      fl = ($urandom_range(0, 99) < 3);
      ch = 8'($urandom);
      step(pv, ch, rd, fl);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (got_ch[d] !== exp_ch[d] || lvl_of(d) !== 5'(mq[d].size()) ||
            rdy_of(d) !== (mq[d].size() < DEPTH) || rdc_of(d) !== mrd[d] || erdc_of(d) !== merd[d]) begin
          errors++;
          $display("FAIL random dut%0d cyc %0d: ch=%h level=%0d rd=%0d erd=%0d, required ch=%h level=%0d rd=%0d erd=%0d",
                   d, n, got_ch[d], lvl_of(d), rdc_of(d), erdc_of(d), exp_ch[d], mq[d].size(), mrd[d], merd[d]);
        end
      end
    end
  endtask

  initial begin
    set_inputs(1'b0, 8'h00, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_order();
    test_full();
    test_gap();
    test_flush();
    test_reset_midgap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
